shared_out_arbiter: RTL and testbench

//   Shares one registered WIDTH-bit output between three requesters (A, B, C) with valid/ready handshakes.

---
 rtl/shared_out_arbiter.sv | 155 +++++++++++++++
 tb/tb_shared_out_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_out_arbiter.sv
// Three-requester arbiter (fixed priority or round-robin) feeding one registered output word.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module shared_out_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rr_mode,
    input  logic             i_a_valid,
    input  logic [WIDTH-1:0] i_a_data,
    output logic             o_a_ready,
    input  logic             i_b_valid,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_b_ready,
    input  logic             i_c_valid,
    input  logic [WIDTH-1:0] i_c_data,
    output logic             o_c_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_src,
    input  logic             i_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       src_q;
    logic [1:0]       ptr_q;

    logic [2:0]       req;
    logic [2:0]       over;
    logic [2:0]       starving;
    logic [2:0]       rot_gnt;
    logic [2:0]       gnt_rr;
    logic [2:0]       gnt;
    logic [2:0]       take;
    logic             load_en;
    logic [1:0]       gnt_id;
    logic [WIDTH-1:0] gnt_data;

    // Bit 0 has highest priority.
    function automatic logic [2:0] pick_first(input logic [2:0] v);
        if (v[0])      return 3'b001;
        else if (v[1]) return 3'b010;
        else if (v[2]) return 3'b100;
        else           return 3'b000;
    endfunction

    assign req      = {i_c_valid, i_b_valid, i_a_valid};
    assign load_en  = (state_q == EMPTY) || i_ready;
    assign starving = req & over;

    // Round-robin: rotate the request vector so the pointer lands on bit 0, pick, rotate back.
    always_comb begin
        rot_gnt = 3'b000;
        gnt_rr  = 3'b000;
        case (ptr_q)
            2'd1: begin
                rot_gnt = pick_first({req[0], req[2], req[1]});
                gnt_rr  = {rot_gnt[1], rot_gnt[0], rot_gnt[2]};
            end
            2'd2: begin
                rot_gnt = pick_first({req[1], req[0], req[2]});
                gnt_rr  = {rot_gnt[0], rot_gnt[2], rot_gnt[1]};
            end
            default: gnt_rr = pick_first(req);
        endcase
    end

    always_comb begin
        if (|starving)
            gnt = pick_first(starving);
        else if (i_rr_mode)
            gnt = gnt_rr;
        else
            gnt = pick_first(req);
    end

    assign take = (load_en && !i_rst) ? gnt : 3'b000;

    always_comb begin
        gnt_id   = 2'd0;
        gnt_data = i_a_data;
        if (gnt[1]) begin
            gnt_id   = 2'd1;
            gnt_data = i_b_data;
        end else if (gnt[2]) begin
            gnt_id   = 2'd2;
            gnt_data = i_c_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else if (|take) begin
            state_q <= FULL;
            data_q  <= gnt_data;
            src_q   <= gnt_id;
            ptr_q   <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
        end else if (load_en) begin
            state_q <= EMPTY;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_wait
            logic [7:0] wait_q;
            logic [7:0] wait_d;

            always_comb begin
                wait_d = wait_q;
                if (!req[gi] || take[gi])
                    wait_d = 8'd0;
                else if (wait_q != 8'hFF)
                    wait_d = wait_q + 8'd1;
            end

            always_ff @(posedge i_clk) begin
                if (i_rst)
                    wait_q <= 8'd0;
                else
                    wait_q <= wait_d;
            end

            assign over[gi] = (wait_q >= 8'(MAX_WAIT));
        end
    endgenerate
`else
    assign over = 3'b000;
`endif

    generate
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
            $error("MAX_WAIT must be in 1..255");
        end
    endgenerate

    assign o_a_ready = take[0];
    assign o_b_ready = take[1];
    assign o_c_ready = take[2];
    assign o_valid   = (state_q == FULL);
    assign o_data    = data_q;
    assign o_src     = src_q;

endmodule

// File: tb/tb_shared_out_arbiter.sv
// Scoreboard bench for shared_out_arbiter: stimulus pushes expected words, a monitor pops on each output handshake.
module tb_shared_out_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_WAIT = 4;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_rr_mode;
    logic             i_a_valid, i_b_valid, i_c_valid;
    logic [WIDTH-1:0] i_a_data, i_b_data, i_c_data;
    logic             o_a_ready, o_b_ready, o_c_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic [1:0]       o_src;
    logic             i_ready;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] dtab [3];

    shared_out_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rr_mode (i_rr_mode),
        .i_a_valid (i_a_valid),
        .i_a_data  (i_a_data),
        .o_a_ready (o_a_ready),
        .i_b_valid (i_b_valid),
        .i_b_data  (i_b_data),
        .o_b_ready (o_b_ready),
        .i_c_valid (i_c_valid),
        .i_c_data  (i_c_data),
        .o_c_ready (o_c_ready),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_src     (o_src),
        .i_ready   (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_ready(input string name, input logic [2:0] exp_r);
        chk(name, {29'd0, o_c_ready, o_b_ready, o_a_ready}, {29'd0, exp_r});
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input logic av, input logic bv, input logic cv);
        i_a_valid = av;
        i_b_valid = bv;
        i_c_valid = cv;
    endtask

    task automatic expect_word(input logic [1:0] src);
        exp_q.push_back({dtab[src], src});
    endtask

    // Monitor: every accepted output word must match the oldest expectation.
    always @(negedge i_clk) begin
        if (i_rst === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1) begin
            exp_t e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word: got data 0x%0h src %0d, expected none", o_data, o_src);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e.data || o_src !== e.src) begin
                    n_bad++;
                    $display("FAIL out_word: got data 0x%0h src %0d, expected data 0x%0h src %0d",
                             o_data, o_src, e.data, e.src);
                end else begin
                    $display("word ok: data 0x%0h src %0d", o_data, o_src);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rr_seq [6];
        logic [1:0] sg_seq [6];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`ifdef ARB_STARVE_GUARD_EN
        sg_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
`else
        sg_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        dtab = '{8'h11, 8'h22, 8'h33};

        i_rst     = 1'b1;
        i_rr_mode = 1'b0;
        i_ready   = 1'b1;
        i_a_data  = 8'h11;
        i_b_data  = 8'h22;
        i_c_data  = 8'h33;
        set_req(1'b1, 1'b1, 1'b1);

        // Reset held two cycles with every requester valid.
        repeat (2) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("rst_valid", {31'd0, o_valid}, 32'd0);
            chk("rst_data", {24'd0, o_data}, 32'd0);
            chk("rst_src", {30'd0, o_src}, 32'd0);
            chk_ready("rst_ready", 3'b000);
        end

        // Fixed priority, all valid: A wins every cycle.
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_word(2'd0);
            @(negedge i_clk);
            chk_ready("fixed_ready", 3'b001);
            tick();
        end
        set_req(1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        chk_ready("fixed_idle_ready", 3'b000);
        tick();
        @(negedge i_clk);
        chk("fixed_drained", {31'd0, o_valid}, 32'd0);

        // Round-robin from a fresh pointer: A,B,C,A,B,C.
        tick();
        i_rst = 1'b1;
        tick();
        i_rst     = 1'b0;
        i_rr_mode = 1'b1;
        set_req(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            expect_word(rr_seq[k]);
            @(negedge i_clk);
            chk_ready("rr_ready", 3'b001 << rr_seq[k]);
            tick();
        end
        set_req(1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        tick();
        @(negedge i_clk);
        chk("rr_drained", {31'd0, o_valid}, 32'd0);

        // Backpressure: B's word held while A waits.
        tick();
        i_rr_mode = 1'b0;
        i_b_data  = 8'h5A;
        dtab[1]   = 8'h5A;
        set_req(1'b0, 1'b1, 1'b0);
        expect_word(2'd1);
        @(negedge i_clk);
        chk_ready("bp_load_b", 3'b010);
        tick();
        set_req(1'b1, 1'b0, 1'b0);
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("bp_hold_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_hold_data", {24'd0, o_data}, 32'h5A);
            chk("bp_hold_src", {30'd0, o_src}, 32'd1);
            chk_ready("bp_hold_ready", 3'b000);
            tick();
        end
        i_ready = 1'b1;
        expect_word(2'd0);
        @(negedge i_clk);
        chk_ready("bp_release_a", 3'b001);
        tick();
        set_req(1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        tick();
        @(negedge i_clk);
        chk("bp_drained", {31'd0, o_valid}, 32'd0);

        // Mid-operation reset: buffered 0x77 discarded, RR pointer back to A.
        tick();
        i_rr_mode = 1'b1;
        i_a_data  = 8'h77;
        set_req(1'b1, 1'b0, 1'b0);
        @(negedge i_clk);
        chk_ready("mr_load_a", 3'b001);
        tick();
        set_req(1'b0, 1'b0, 1'b0);
        i_ready = 1'b0;
        @(negedge i_clk);
        chk("mr_full_data", {24'd0, o_data}, 32'h77);
        tick();
        i_rst = 1'b1;
        @(negedge i_clk);
        chk_ready("mr_rst_ready", 3'b000);
        tick();
        i_rst    = 1'b0;
        i_a_data = 8'h11;
        i_ready  = 1'b1;
        set_req(1'b1, 1'b1, 1'b1);
        expect_word(2'd0);
        @(negedge i_clk);
        chk("mr_valid_cleared", {31'd0, o_valid}, 32'd0);
        chk("mr_data_cleared", {24'd0, o_data}, 32'd0);
        chk_ready("mr_ptr_at_a", 3'b001);
        tick();
        expect_word(2'd1);
        @(negedge i_clk);
        chk_ready("mr_ptr_next_b", 3'b010);
        tick();
        set_req(1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        tick();

        // Fixed mode, A and C continuously valid: C only wins through the starvation guard.
        i_rst = 1'b1;
        tick();
        i_rst     = 1'b0;
        i_rr_mode = 1'b0;
        set_req(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            expect_word(sg_seq[k]);
            @(negedge i_clk);
            chk_ready("starve_ready", 3'b001 << sg_seq[k]);
            tick();
        end
        set_req(1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        tick();
        @(negedge i_clk);
        chk("starve_drained", {31'd0, o_valid}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
